// File: rtl/count_display_ctrl_pkg.sv
// Shared constants for the count display: active-low 7-segment patterns {g..a}
// and the BCD digit type used by the wrap counter and segment encoder.
package count_display_ctrl_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Non-numeric codes fed to the encoder
  localparam bcd_t CODE_E     = 4'hE;
  localparam bcd_t CODE_BLANK = 4'hF;

endpackage

// File: rtl/count_display_ctrl_seg7_encode.sv
// Combinational 4-bit code to active-low 7-segment pattern; 0-9 are digits,
// CODE_E shows 'E', anything else is blank.
module seg7_encode
  import count_display_ctrl_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      CODE_E:  seg = SEG_E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display_ctrl.sv
// Consumer of the ripple mod-N counter: synchronises and de-glitches its count,
// counts wraps in BCD and scans a 4-digit multiplexed 7-segment display.
module count_display_ctrl
  import count_display_ctrl_pkg::*;
#(
  parameter int MOD           = 5,
  parameter int STABLE_CYCLES = 4,
  parameter int REFRESH_DIV   = 16
) (
  input  logic       clock1,
  input  logic       rst,
  input  logic       qa,
  input  logic       qb,
  input  logic       qc,
  input  logic       clr,
  output logic [2:0] digit,
  output logic [7:0] wrap_cnt,
  output logic       wrap_p,
  output logic       err,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int             STW     = $clog2(STABLE_CYCLES + 1);
  localparam logic [STW-1:0] STB_MAX = STW'(STABLE_CYCLES);
  localparam logic [STW-1:0] STB_ACC = STW'(STABLE_CYCLES - 1);
  localparam logic [2:0]     MOD_L   = 3'(MOD);
  localparam logic [2:0]     LAST_L  = 3'(MOD - 1);

  logic [2:0]             sync_p0, sync_p1;
  logic [2:0]             s2, cand, last_acc;
  logic [STW-1:0]         stable;
  logic                   accept, legal, wrap;
  logic [REFRESH_DIV-1:0] refresh;
  logic [1:0]             idx;
  logic                   scan_on;
  bcd_t                   code;
  logic [6:0]             seg_pat;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    bcd_t ones, tens;
    ones = v[3:0];
    tens = v[7:4];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  // Stage p0/p1: two-flop synchroniser on the raw active-low bits
  always_ff @(posedge clock1 or posedge rst) begin
    if (rst) begin
      sync_p0 <= 3'b111;
      sync_p1 <= 3'b111;
    end else begin
      sync_p0 <= {qc, qb, qa};
      sync_p1 <= sync_p0;
    end
  end

  assign s2 = ~sync_p1;

  // Accept lands on the same edge the stable count reaches STABLE_CYCLES.
  // last_acc also remembers illegal values so they neither re-fire nor let
  // the following 0 look like a wrap.
  assign accept = (s2 == cand) && (stable >= STB_ACC) && (cand != last_acc);
  assign legal  = (cand < MOD_L);
  assign wrap   = accept && legal && (last_acc == LAST_L) && (cand == 3'd0);

  always_ff @(posedge clock1 or posedge rst) begin
    if (rst) begin
      cand     <= 3'd0;
      stable   <= '0;
      last_acc <= 3'd0;
      digit    <= 3'd0;
      wrap_cnt <= 8'h00;
      wrap_p   <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (s2 != cand) begin
        cand   <= s2;
        stable <= STW'(1);
      end else if (stable != STB_MAX) begin
        stable <= stable + 1'b1;
      end
      if (accept) last_acc <= cand;
      if (accept && legal) digit <= cand;
      wrap_p <= wrap;
      if (clr) begin
        wrap_cnt <= 8'h00;
        err      <= 1'b0;
      end else begin
        if (wrap) wrap_cnt <= bcd_inc(wrap_cnt);
        if (accept && !legal) err <= 1'b1;
      end
    end
  end

  always_comb begin
    code = CODE_BLANK;
    case (idx)
      2'd0:    code = {1'b0, digit};
      2'd1:    code = wrap_cnt[3:0];
      2'd2:    code = wrap_cnt[7:4];
      default: code = err ? CODE_E : CODE_BLANK;
    endcase
  end

  seg7_encode u_seg7_encode (
    .code (code),
    .seg  (seg_pat)
  );

  // Display scan: outputs follow the index one cycle after it advances
  always_ff @(posedge clock1 or posedge rst) begin
    if (rst) begin
      refresh <= '0;
      idx     <= 2'd0;
      scan_on <= 1'b0;
      an      <= 4'b1111;
      seg     <= SEG_BLANK;
    end else begin
      refresh <= refresh + 1'b1;
      if (&refresh) begin
        idx     <= idx + 2'd1;
        scan_on <= 1'b1;
      end
      if (scan_on) begin
        an  <= ~(4'b0001 << idx);
        seg <= seg_pat;
      end
    end
  end

endmodule

// File: tb/tb_count_display_ctrl.sv
// Bench for count_display_ctrl: directed scenarios plus randomized count
// sequences checked against a value-level reference model.
module tb_count_display_ctrl;

  localparam int STABLE = 2;

  logic       clock1 = 1'b0;
  logic       rst = 1'b1;
  logic       qa = 1'b1, qb = 1'b1, qc = 1'b1;
  logic       clr = 1'b0;
  logic [2:0] digit;
  logic [7:0] wrap_cnt;
  logic       wrap_p;
  logic       err;
  logic [6:0] seg;
  logic [3:0] an;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  // Reference model state: what the display should show, by value
  int m_digit = 0, m_last = 0, m_wraps = 0, exp_pulses = 0;
  bit m_err = 1'b0;

  count_display_ctrl #(.MOD(5), .STABLE_CYCLES(STABLE), .REFRESH_DIV(3)) dut (
    .clock1   (clock1),
    .rst      (rst),
    .qa       (qa),
    .qb       (qb),
    .qc       (qc),
    .clr      (clr),
    .digit    (digit),
    .wrap_cnt (wrap_cnt),
    .wrap_p   (wrap_p),
    .err      (err),
    .seg      (seg),
    .an       (an)
  );

  always #5 clock1 = ~clock1;

  always @(posedge clock1) begin
    #1;
    if (!rst && wrap_p) pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [7:0] bcd_of(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_raw(input logic [2:0] v);
    {qc, qb, qa} = ~v;
  endtask

  // A value held long enough becomes the accepted count
  task automatic model_apply(input int v);
    if (v != m_last) begin
      if (v < 5) begin
        if (m_last == 4 && v == 0) begin
          m_wraps = (m_wraps + 1) % 100;
          exp_pulses++;
        end
        m_digit = v;
      end else begin
        m_err = 1'b1;
      end
      m_last = v;
    end
  endtask

  task automatic model_reset();
    m_digit = 0; m_last = 0; m_wraps = 0; m_err = 1'b0; exp_pulses = pulses;
  endtask

  task automatic hold(input int v, input int n);
    set_raw(3'(v));
    repeat (n) @(negedge clock1);
    model_apply(v);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clock1);
    clr = 1'b0;
    m_wraps = 0;
    m_err = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_digit"}, 32'(digit), 32'(m_digit));
    check({tag, "_err"}, 32'(err), 32'(m_err));
    check({tag, "_wrap_cnt"}, 32'(wrap_cnt), 32'(bcd_of(m_wraps)));
    check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_digit"}, 32'(digit), 32'h0);
    check({tag, "_wrap_cnt"}, 32'(wrap_cnt), 32'h00);
    check({tag, "_wrap_p"}, 32'(wrap_p), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_an"}, 32'(an), 32'hF);
  endtask

  initial begin
    int cnt[4];
    logic [2:0] gv;
    int v;
    int n;

    // Power-on reset
    repeat (3) @(negedge clock1);
    check_reset("por");
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clock1);
    check("an_before_first_advance", 32'(an), 32'hF);

    // Three full count cycles
    for (int c = 0; c < 3; c++) begin
      for (int k = 1; k <= 5; k++) hold(k % 5, 10);
      check_state($sformatf("cycle%0d", c));
    end
    check("three_wraps", 32'(wrap_cnt), 32'h03);

    // One-clock glitch while holding 2
    hold(1, 10);
    hold(2, 10);
    set_raw(3'd6);
    @(negedge clock1);
    hold(2, 10);
    check("glitch_digit", 32'(digit), 32'd2);
    check("glitch_err", 32'(err), 32'd0);

    // Illegal 5 after 4, then 0 must not wrap; clr drops err
    hold(3, 10);
    hold(4, 10);
    hold(5, 10);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_digit_held", 32'(digit), 32'd4);
    hold(0, 10);
    check_state("zero_after_illegal");
    do_clr();
    check("clr_err", 32'(err), 32'd0);
    check("clr_wrap_cnt", 32'(wrap_cnt), 32'h00);

    // Randomized sequences with occasional one-clock glitches
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        gv = 3'($urandom_range(0, 7));
        set_raw(gv);
        @(negedge clock1);
      end
      if ($urandom_range(0, 4) == 0) v = $urandom_range(0, 7);
      else v = (m_digit + 1) % 5;
      n = $urandom_range(STABLE + 3, 9);
      hold(v, n);
      check_state($sformatf("rand%0d", s));
    end

    // Asynchronous reset mid-run
    hold(3, 10);
    #2;
    rst = 1'b1;
    #1;
    check_reset("midrun_rst");
    set_raw(3'd0);
    repeat (3) @(negedge clock1);
    rst = 1'b0;
    model_reset();
    hold(0, 10);
    check_state("after_rst");

    // Preload 99 wraps, then one more rolls to 00 with a pulse
    for (int w = 0; w < 99; w++)
      for (int k = 1; k <= 5; k++) hold(k % 5, 5);
    check("preload_99", 32'(wrap_cnt), 32'h99);
    for (int k = 1; k <= 4; k++) hold(k, 5);
    set_raw(3'd0);
    repeat (STABLE + 2) @(negedge clock1);
    check("rollover_wrap_p", 32'(wrap_p), 32'd1);
    check("rollover_wrap_cnt", 32'(wrap_cnt), 32'h00);
    hold(0, 4);
    check_state("after_rollover");

    // clr on the very cycle a wrap is accepted
    for (int k = 1; k <= 5; k++) hold(k % 5, 6);
    hold(1, 6); hold(2, 6); hold(3, 6); hold(4, 6);
    set_raw(3'd0);
    repeat (STABLE + 1) @(negedge clock1);
    clr = 1'b1;
    @(negedge clock1);
    clr = 1'b0;
    check("clr_vs_wrap_pulse", 32'(wrap_p), 32'd1);
    check("clr_vs_wrap_cnt", 32'(wrap_cnt), 32'h00);
    model_apply(0);
    m_wraps = 0;
    m_err = 1'b0;
    hold(0, 4);
    check_state("after_clr_wrap");

    // Display scan with digit 3 and wrap count 12
    for (int w = 0; w < 12; w++)
      for (int k = 1; k <= 5; k++) hold(k % 5, 5);
    hold(1, 5); hold(2, 5); hold(3, 10);
    check("scan_setup_wraps", 32'(wrap_cnt), 32'h12);
    cnt = '{0, 0, 0, 0};
    for (int i = 0; i < 32; i++) begin
      case (an)
        4'b1110: begin cnt[0]++; check("scan_seg_digit", 32'(seg), 32'(seg_of(m_digit))); end
        4'b1101: begin cnt[1]++; check("scan_seg_ones", 32'(seg), 32'(seg_of(m_wraps % 10))); end
        4'b1011: begin cnt[2]++; check("scan_seg_tens", 32'(seg), 32'(seg_of(m_wraps / 10))); end
        4'b0111: begin cnt[3]++; check("scan_seg_err", 32'(seg), m_err ? 32'h06 : 32'h7F); end
        default: check("scan_an_onehot", 32'(an), 32'hE);
      endcase
      @(negedge clock1);
    end
    for (int d = 0; d < 4; d++) check($sformatf("scan_dwell%0d", d), 32'(cnt[d]), 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
